// File: rtl/lpa_result_serializer_pkg.sv
// Shared types and sizing helpers for the LPA result serializer.
//   lane_count : total parallel result lanes from PE and batch dimensions
//   idx_width  : width of the drain index (never below 1 bit)
//   state_t    : serializer FSM states
package lpa_result_serializer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    function automatic int unsigned lane_count(input int unsigned pe_i, input int unsigned batch);
        return pe_i * batch;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lpa_lane_holding_reg.sv
// One-beat holding register for a single result lane.
//   clk, rst_n     : clock, async active-low reset
//   accept_en      : lane may accept a beat (serializer collecting)
//   clr            : drop the held beat after the group has drained
//   in_valid/in_ready_c and in_* : input beat and handshake
//   full, q_*      : occupancy flag and held beat fields
module lpa_lane_holding_reg #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  accept_en,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready_c,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic [DEST_WIDTH-1:0] in_dest,
    input  logic [USER_WIDTH-1:0] in_user,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] q_data,
    output logic                  q_last,
    output logic [ID_WIDTH-1:0]   q_id,
    output logic [DEST_WIDTH-1:0] q_dest,
    output logic [USER_WIDTH-1:0] q_user
);

    logic capture_c;

    assign in_ready_c = accept_en && !full;
    assign capture_c  = in_valid && in_ready_c;

    // Occupancy flag and captured fields
    always_ff @(posedge clk or negedge rst_n) begin : p_hold
        if (!rst_n) begin
            full   <= 1'b0;
            q_data <= '0;
            q_last <= 1'b0;
            q_id   <= '0;
            q_dest <= '0;
            q_user <= '0;
        end else begin
            if (clr) begin
                full <= 1'b0;
            end else if (capture_c) begin
                full <= 1'b1;
            end
            if (capture_c) begin
                q_data <= in_data;
                q_last <= in_last;
                q_id   <= in_id;
                q_dest <= in_dest;
                q_user <= in_user;
            end
        end
    end

endmodule

// File: rtl/lpa_result_serializer.sv
// Collects one beat from each of the N parallel result lanes, then emits the
// group on a single AXI-Stream in ascending lane order.
//   clk, rst_n           : clock, async active-low reset
//   s_axis_d_*           : N parallel input lanes (lane k at slice k)
//   m_axis_*             : serialized output stream
//   err_clr              : clears the sticky tlast-alignment error
//   err_unaligned_last   : sticky, captured lanes disagreed on tlast
//   busy                 : any lane holds data or a group is draining
module lpa_result_serializer
    import lpa_result_serializer_pkg::*;
#(
    parameter int unsigned PE_NUMBER_I = 1,
    parameter int unsigned BATCH_SIZE  = 1,
    parameter int unsigned RSLT_WIDTH  = 16,
    parameter int unsigned ID_ENABLE   = 0,
    parameter int unsigned ID_WIDTH    = (ID_ENABLE != 0) ? 8 : 1,
    parameter int unsigned DEST_ENABLE = 0,
    parameter int unsigned DEST_WIDTH  = (DEST_ENABLE != 0) ? 8 : 1,
    parameter int unsigned USER_ENABLE = 0,
    parameter int unsigned USER_WIDTH  = (USER_ENABLE != 0) ? 8 : 1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [PE_NUMBER_I*BATCH_SIZE*RSLT_WIDTH-1:0]  s_axis_d_tdata,
    input  logic [PE_NUMBER_I*BATCH_SIZE-1:0]             s_axis_d_tvalid,
    output logic [PE_NUMBER_I*BATCH_SIZE-1:0]             s_axis_d_tready,
    input  logic [PE_NUMBER_I*BATCH_SIZE-1:0]             s_axis_d_tlast,
    input  logic [PE_NUMBER_I*BATCH_SIZE*ID_WIDTH-1:0]    s_axis_d_tid,
    input  logic [PE_NUMBER_I*BATCH_SIZE*DEST_WIDTH-1:0]  s_axis_d_tdest,
    input  logic [PE_NUMBER_I*BATCH_SIZE*USER_WIDTH-1:0]  s_axis_d_tuser,
    output logic [RSLT_WIDTH-1:0]                         m_axis_tdata,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]                           m_axis_tid,
    output logic [DEST_WIDTH-1:0]                         m_axis_tdest,
    output logic [USER_WIDTH-1:0]                         m_axis_tuser,
    input  logic                                          err_clr,
    output logic                                          err_unaligned_last,
    output logic                                          busy
);

    localparam int unsigned N     = lane_count(PE_NUMBER_I, BATCH_SIZE);
    localparam int unsigned IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(N - 1);
    localparam logic [ID_WIDTH-1:0]   ID_MASK   = {ID_WIDTH{ID_ENABLE != 0}};
    localparam logic [DEST_WIDTH-1:0] DEST_MASK = {DEST_WIDTH{DEST_ENABLE != 0}};
    localparam logic [USER_WIDTH-1:0] USER_MASK = {USER_WIDTH{USER_ENABLE != 0}};

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tvalid_d, tlast_d, err_d;
    logic             load_c, grp_clr_c, collect_en_c;
    logic [IDX_W-1:0] ld_idx_c;

    logic [N-1:0]          lane_full;
    logic [N-1:0]          lane_last;
    logic [RSLT_WIDTH-1:0] lane_data [N];
    logic [ID_WIDTH-1:0]   lane_id   [N];
    logic [DEST_WIDTH-1:0] lane_dest [N];
    logic [USER_WIDTH-1:0] lane_user [N];

    logic [RSLT_WIDTH-1:0] sel_data;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [DEST_WIDTH-1:0] sel_dest;
    logic [USER_WIDTH-1:0] sel_user;

    logic all_full, all_last, any_last;

    // Lanes accept only while collecting; rst_n keeps tready low during reset
    assign collect_en_c = rst_n && (state_q == COLLECT);
    assign all_full     = &lane_full;
    assign all_last     = &lane_last;
    assign any_last     = |lane_last;
    assign busy         = (|lane_full) || (state_q == DRAIN);

    // Per-lane holding registers
    for (genvar k = 0; k < N; k++) begin : g_lane
        lpa_lane_holding_reg #(
            .DATA_WIDTH (RSLT_WIDTH),
            .ID_WIDTH   (ID_WIDTH),
            .DEST_WIDTH (DEST_WIDTH),
            .USER_WIDTH (USER_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .accept_en  (collect_en_c),
            .clr        (grp_clr_c),
            .in_valid   (s_axis_d_tvalid[k]),
            .in_ready_c (s_axis_d_tready[k]),
            .in_data    (s_axis_d_tdata[k*RSLT_WIDTH +: RSLT_WIDTH]),
            .in_last    (s_axis_d_tlast[k]),
            .in_id      (s_axis_d_tid[k*ID_WIDTH +: ID_WIDTH]),
            .in_dest    (s_axis_d_tdest[k*DEST_WIDTH +: DEST_WIDTH]),
            .in_user    (s_axis_d_tuser[k*USER_WIDTH +: USER_WIDTH]),
            .full       (lane_full[k]),
            .q_data     (lane_data[k]),
            .q_last     (lane_last[k]),
            .q_id       (lane_id[k]),
            .q_dest     (lane_dest[k]),
            .q_user     (lane_user[k])
        );
    end

    // Select the lane that will be presented on the next output beat
    always_comb begin : p_lane_mux
        sel_data = '0;
        sel_id   = '0;
        sel_dest = '0;
        sel_user = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (ld_idx_c == IDX_W'(k)) begin
                sel_data = lane_data[k];
                sel_id   = lane_id[k];
                sel_dest = lane_dest[k];
                sel_user = lane_user[k];
            end
        end
    end

    // Next-state and output-register control
    always_comb begin : p_fsm_comb
        state_d   = state_q;
        idx_d     = idx_q;
        tvalid_d  = m_axis_tvalid;
        tlast_d   = m_axis_tlast;
        err_d     = err_unaligned_last && !err_clr;
        load_c    = 1'b0;
        grp_clr_c = 1'b0;
        ld_idx_c  = idx_q;
        unique case (state_q)
            COLLECT: begin
                if (all_full) begin
                    state_d  = DRAIN;
                    idx_d    = '0;
                    tvalid_d = 1'b1;
                    load_c   = 1'b1;
                    ld_idx_c = '0;
                    tlast_d  = (LAST_IDX == '0) && all_last;
                    // Mixed tlast across lanes; setting beats a coincident clear
                    if (any_last && !all_last) begin
                        err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (m_axis_tready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d   = COLLECT;
                        idx_d     = '0;
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        grp_clr_c = 1'b1;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        load_c   = 1'b1;
                        ld_idx_c = idx_q + IDX_W'(1);
                        tlast_d  = ((idx_q + IDX_W'(1)) == LAST_IDX) && all_last;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State, index, handshake and error registers
    always_ff @(posedge clk or negedge rst_n) begin : p_fsm_reg
        if (!rst_n) begin
            state_q            <= COLLECT;
            idx_q              <= '0;
            m_axis_tvalid      <= 1'b0;
            m_axis_tlast       <= 1'b0;
            err_unaligned_last <= 1'b0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            m_axis_tvalid      <= tvalid_d;
            m_axis_tlast       <= tlast_d;
            err_unaligned_last <= err_d;
        end
    end

    // Output payload; disabled sideband fields are forced to zero
    always_ff @(posedge clk or negedge rst_n) begin : p_out_fields
        if (!rst_n) begin
            m_axis_tdata <= '0;
            m_axis_tid   <= '0;
            m_axis_tdest <= '0;
            m_axis_tuser <= '0;
        end else if (load_c) begin
            m_axis_tdata <= sel_data;
            m_axis_tid   <= sel_id & ID_MASK;
            m_axis_tdest <= sel_dest & DEST_MASK;
            m_axis_tuser <= sel_user & USER_MASK;
        end
    end

endmodule

// File: tb/tb_lpa_result_serializer.sv
// Self-checking bench for lpa_result_serializer (2x2 lanes, tid enabled).
module tb_lpa_result_serializer;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  s_tdata;
    logic [N-1:0]    s_tvalid, s_tready, s_tlast, s_tdest, s_tuser;
    logic [N*IW-1:0] s_tid;
    logic [W-1:0]    m_tdata;
    logic            m_tvalid, m_tready, m_tlast, m_tdest, m_tuser;
    logic [IW-1:0]   m_tid;
    logic            err_clr, err, busy;

    typedef struct packed {
        logic [W-1:0]  data;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    lpa_result_serializer #(
        .PE_NUMBER_I (2),
        .BATCH_SIZE  (2),
        .RSLT_WIDTH  (16),
        .ID_ENABLE   (1),
        .DEST_ENABLE (0),
        .USER_ENABLE (0)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axis_d_tdata     (s_tdata),
        .s_axis_d_tvalid    (s_tvalid),
        .s_axis_d_tready    (s_tready),
        .s_axis_d_tlast     (s_tlast),
        .s_axis_d_tid       (s_tid),
        .s_axis_d_tdest     (s_tdest),
        .s_axis_d_tuser     (s_tuser),
        .m_axis_tdata       (m_tdata),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tready      (m_tready),
        .m_axis_tlast       (m_tlast),
        .m_axis_tid         (m_tid),
        .m_axis_tdest       (m_tdest),
        .m_axis_tuser       (m_tuser),
        .err_clr            (err_clr),
        .err_unaligned_last (err),
        .busy               (busy)
    );

    // Output monitor: scoreboard pop on each handshake, hold check after stalls
    initial begin : p_monitor
        beat_t      e;
        logic       prev_stall;
        logic [W-1:0] prev_data;
        logic       prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                                 m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
                    end
                end
                if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: data=%h last=%b, required no beat", m_tdata, m_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_tdata !== e.data || m_tlast !== e.last || m_tid !== e.id ||
                            m_tdest !== 1'b0 || m_tuser !== 1'b0) begin
                            errors++;
                            $display("FAIL beat: data=%h last=%b id=%0d dest=%b user=%b, required data=%h last=%b id=%0d dest=0 user=0",
                                     m_tdata, m_tlast, m_tid, m_tdest, m_tuser, e.data, e.last, e.id);
                        end
                    end
                end
                prev_stall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present one group; lane k becomes valid at cycle off[k] and holds until accepted
    task automatic drive_group(input logic [N*W-1:0] d, input logic [N-1:0] lst,
                               input logic [N*IW-1:0] ids, input logic [N-1:0][7:0] off);
        logic [N-1:0] done, acc;
        int    cyc;
        beat_t b;
        done = '0;
        cyc  = 0;
        for (int k = 0; k < N; k++) begin
            b.data = d[k*W +: W];
            b.last = (k == N - 1) && (&lst);
            b.id   = ids[k*IW +: IW];
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        while (done != '1 && cyc < 100) begin
            for (int k = 0; k < N; k++) begin
                if (!done[k] && !s_tvalid[k] && off[k] == 8'(cyc)) begin
                    s_tvalid[k]          = 1'b1;
                    s_tdata[k*W +: W]    = d[k*W +: W];
                    s_tlast[k]           = lst[k];
                    s_tid[k*IW +: IW]    = ids[k*IW +: IW];
                    s_tdest[k]           = 1'($urandom);
                    s_tuser[k]           = 1'($urandom);
                end
            end
            @(negedge clk);
            checks++;
            if (m_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL early_output: tvalid=%b at cycle %0d, required 0", m_tvalid, cyc);
            end
            checks++;
            if ((s_tready & done) !== '0) begin
                errors++;
                $display("FAIL ready_held: tready=%b done=%b, required 0 on captured lanes", s_tready, done);
            end
            acc = s_tvalid & s_tready;
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    s_tvalid[k] = 1'b0;
                    done[k]     = 1'b1;
                end
            end
            cyc++;
        end
        checks++;
        if (done != '1) begin
            errors++;
            $display("FAIL capture_timeout: captured=%b, required 1111", done);
        end
    endtask

    // Run tready pattern until only stop_at beats remain; on full drain check the idle state
    task automatic wait_drain(input logic [3:0] pat, input int stop_at, output int cyc);
        cyc = 0;
        while (exp_q.size() > stop_at && cyc < 200) begin
            m_tready = pat[cyc % 4];
            @(posedge clk); #1;
            cyc++;
        end
        m_tready = 1'b1;
        checks++;
        if (exp_q.size() != stop_at) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats left, required %0d", exp_q.size(), stop_at);
        end
        if (stop_at == 0) begin
            @(negedge clk);
            checks++;
            if (m_tvalid !== 1'b0 || s_tready !== 4'hF || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_drain: tvalid=%b tready=%b busy=%b, required tvalid=0 tready=1111 busy=0",
                         m_tvalid, s_tready, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tid !== '0) begin
            errors++;
            $display("FAIL reset_out: tvalid=%b tlast=%b tdata=%h tid=%h, required all 0", m_tvalid, m_tlast, m_tdata, m_tid);
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: err=%b busy=%b, required 0 0", err, busy);
        end
        checks++;
        if (s_tready !== 4'h0) begin
            errors++;
            $display("FAIL reset_ready: tready=%b, required 0000", s_tready);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 4'hF) begin
            errors++;
            $display("FAIL ready_after_reset: tready=%b, required 1111", s_tready);
        end
    endtask

    task automatic test_basic();
        int c;
        drive_group({16'h0044, 16'h0033, 16'h0022, 16'h0011}, 4'b1111, {8'd9, 8'd8, 8'd7, 8'd6}, '0);
        wait_drain(4'b1111, 0, c);
        checks++;
        if (c != 5) begin
            errors++;
            $display("FAIL basic_latency: %0d cycles to drain, required 5", c);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err: err=%b, required 0", err);
        end
    endtask

    task automatic test_staggered();
        int c;
        drive_group({16'h0D04, 16'h0C03, 16'h0B02, 16'h0A01}, 4'b1111, {8'd1, 8'd2, 8'd3, 8'd4},
                    {8'd9, 8'd5, 8'd3, 8'd0});
        wait_drain(4'b1111, 0, c);
        checks++;
        if (c != 5) begin
            errors++;
            $display("FAIL staggered_latency: %0d cycles to drain, required 5", c);
        end
    endtask

    task automatic test_unaligned();
        int c;
        drive_group({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'b0101, {8'd0, 8'd0, 8'd0, 8'd0}, '0);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_early: err=%b before drain entry, required 0", err);
        end
        wait_drain(4'b1111, 0, c);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b, required 1", err);
        end
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b, required 0", err);
        end
        // Hold err_clr through the edge that detects a new mismatch
        err_clr = 1'b1;
        drive_group({16'h0404, 16'h0303, 16'h0202, 16'h0101}, 4'b0011, {8'd1, 8'd1, 8'd1, 8'd1}, '0);
        @(posedge clk); #1 err_clr = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins: err=%b, required 1", err);
        end
        wait_drain(4'b1111, 0, c);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    task automatic test_stall();
        int c;
        drive_group({16'hD00D, 16'hC00C, 16'hB00B, 16'hA00A}, 4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, '0);
        wait_drain(4'b1001, 0, c);
    endtask

    task automatic test_reset_mid_drain();
        int c;
        drive_group({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'b1111, {8'd0, 8'd0, 8'd0, 8'd0}, '0);
        wait_drain(4'b1111, 2, c);
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: tvalid=%b tready=%b busy=%b, required 0 0000 0", m_tvalid, s_tready, busy);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive_group({16'h0DDD, 16'h0CCC, 16'h0BBB, 16'h0AAA}, 4'b1111, {8'd6, 8'd5, 8'd4, 8'd3}, '0);
        wait_drain(4'b1111, 0, c);
    endtask

    task automatic test_tid();
        int c;
        drive_group({16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01}, 4'b0000, {8'd6, 8'd5, 8'd4, 8'd3},
                    {8'd1, 8'd0, 8'd2, 8'd1});
        wait_drain(4'b1101, 0, c);
    endtask

    task automatic test_back_to_back();
        int c;
        logic [N*W-1:0]     d;
        logic [N*IW-1:0]    ids;
        logic [N-1:0][7:0]  off;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < N; k++) begin
                d[k*W +: W]    = 16'($urandom);
                ids[k*IW +: IW] = 8'($urandom);
                off[k]          = 8'($urandom_range(0, 6));
            end
            drive_group(d, (g % 2 == 0) ? 4'b1111 : 4'b0000, ids, off);
            wait_drain(4'($urandom_range(1, 15)), 0, c);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL random_err: err=%b, required 0", err);
        end
    endtask

    initial begin : p_main
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tid    = '0;
        s_tdest  = '0;
        s_tuser  = '0;
        m_tready = 1'b1;
        err_clr  = 1'b0;
        test_reset();
        test_basic();
        test_staggered();
        test_unaligned();
        test_stall();
        test_reset_mid_drain();
        test_tid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
